// File: rtl/alu16_sequencer.sv
// Command sequencer for an external combinational alu16: issues single ops or a
// full opcode sweep and queues {Y,N,Z,C,op} results in a show-ahead FIFO.
module alu16_sequencer #(
  parameter int DW    = 16,
  parameter int OPW   = 4,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [DW-1:0]  cmd_r,
  input  logic [DW-1:0]  cmd_s,
  input  logic [OPW-1:0] cmd_op,
  input  logic           sweep_start,
  output logic [DW-1:0]  alu_r,
  output logic [DW-1:0]  alu_s,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_y,
  input  logic           alu_n,
  input  logic           alu_z,
  input  logic           alu_c,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_y,
  output logic           res_n,
  output logic           res_z,
  output logic           res_c,
  output logic [OPW-1:0] res_op,
  output logic           busy,
  output logic           sweep_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]  FULL    = CW'(DEPTH);
  localparam logic [OPW-1:0] LAST_OP = '1;

  typedef enum logic [1:0] {IDLE, EXEC, SW_ISSUE, SW_EXEC} state_t;
  typedef struct packed {
    logic [DW-1:0]  y;
    logic           n;
    logic           z;
    logic           c;
    logic [OPW-1:0] op;
  } res_t;

  state_t         r_state;
  logic [DW-1:0]  r_alu_r, r_alu_s;
  logic [OPW-1:0] r_alu_op, r_cnt;
  logic           r_done;
  res_t           r_mem [DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [CW-1:0]  r_count;

  logic w_push, w_pop, w_space;
  res_t w_in, w_head;

  assign w_push    = (r_state == EXEC) || (r_state == SW_EXEC);
  assign res_valid = (r_count != '0);
  assign w_pop     = res_valid && res_ready;
  // A pop in the same cycle frees a slot in time for the next push.
  assign w_space   = (r_count < FULL) || w_pop;
  assign cmd_ready = (r_state == IDLE) && (r_count < FULL) && !sweep_start;
  assign w_in      = {alu_y, alu_n, alu_z, alu_c, r_alu_op};
  assign w_head    = res_valid ? r_mem[r_rd] : '0;

  assign alu_r      = r_alu_r;
  assign alu_s      = r_alu_s;
  assign alu_op     = r_alu_op;
  assign busy       = (r_state != IDLE);
  assign sweep_done = r_done;
  assign res_y      = w_head.y;
  assign res_n      = w_head.n;
  assign res_z      = w_head.z;
  assign res_c      = w_head.c;
  assign res_op     = w_head.op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_alu_r  <= '0;
      r_alu_s  <= '0;
      r_alu_op <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (sweep_start) begin
            r_alu_r <= cmd_r;
            r_alu_s <= cmd_s;
            r_cnt   <= '0;
            r_state <= SW_ISSUE;
          end else if (cmd_valid && cmd_ready) begin
            r_alu_r  <= cmd_r;
            r_alu_s  <= cmd_s;
            r_alu_op <= cmd_op;
            r_state  <= EXEC;
          end
        end
        EXEC: r_state <= IDLE;
        SW_ISSUE: begin
          if (w_space) begin
            r_alu_op <= r_cnt;
            r_state  <= SW_EXEC;
          end
        end
        SW_EXEC: begin
          if (r_cnt == LAST_OP) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= SW_ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr] <= w_in;
  end
endmodule
